// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter.
//   uart_state_t  : transmitter FSM state encoding
//   TX_IDLE_LEVEL : level of the serial line between frames
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of a synchronous FIFO as seen by its consumer.
//   rd_en    : one-cycle pop request (consumer -> FIFO)
//   data_out : read data, valid the cycle after rd_en (FIFO -> consumer)
//   empty    : FIFO empty flag (FIFO -> consumer)
// master = consumer side, slave = FIFO side.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;

  modport master (
    output rd_en,
    input  data_out,
    input  empty
  );

  modport slave (
    input  rd_en,
    output data_out,
    output empty
  );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer for the UART transmitter.
//   clk, rst_n : system clock, async active-low reset
//   clear      : restart the bit period from zero on the next edge
//   tick       : high in the last cycle of each bit period
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO one word at a time.
// Each word becomes a frame: start bit, data LSB-first, optional even
// parity, one or two stop bits.
//   clk, rst_n : system clock, async active-low reset
//   enable     : allows a new frame to start (only looked at in IDLE)
//   fifo       : FIFO read port (rd_en out, data_out/empty in)
//   tx         : serial line, idle high, registered
//   busy       : high while a frame is in progress
//   frame_done : one-cycle pulse in the final cycle of the last stop bit
//
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// LOAD   | popped word arrives from the FIFO and is captured
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity over the data bits
// STOP   | stop bit(s) (high)
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_state_t           state, state_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic                  par_q, par_n;
  logic [BIT_W-1:0]      bit_q, bit_n;
  logic                  tx_q, tx_n;
  logic                  armed_q;
  logic                  rd_en;
  logic                  tick;
  logic                  clear;

  // The baud timer restarts whenever the FSM changes state, so every state
  // begins with a full bit period.
  assign clear = (state_n != state);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      tx_q    <= TX_IDLE_LEVEL;
      armed_q <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      bit_q   <= bit_n;
      tx_q    <= tx_n;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    par_n   = par_q;
    bit_n   = bit_q;
    rd_en   = 1'b0;
    case (state)
      IDLE: begin
        // Pop in the IDLE cycle itself so the word is on data_out during
        // LOAD. armed_q keeps the pop off while reset is (or was just) low.
        if (armed_q && enable && !fifo.empty) begin
          rd_en   = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        shift_n = fifo.data_out;
        par_n   = 1'b0;
        bit_n   = '0;
        state_n = START;
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          par_n   = par_q ^ shift_q[0];
          shift_n = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          bit_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            state_n = IDLE;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the level the next state will drive.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = TX_IDLE_LEVEL;
    endcase
  end

  assign fifo.rd_en = rd_en;
  assign tx         = tx_q;
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && tick && (bit_q == STOP_LAST);

endmodule
